// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared definitions for the SPI command sequencer: FSM encoding, command word
// field positions and default sizing.
package spi_cmd_sequencer_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWaitStart,
      StWaitDone
   } state_e;

   localparam int unsigned CMD_CS_BIT    = 15;
   localparam int unsigned CMD_CNT_MSB   = 11;
   localparam int unsigned CMD_CNT_LSB   = 8;
   localparam int unsigned CMD_CS_LVL    = 0;

   localparam int unsigned DEFAULT_DEPTH = 16;
   localparam int unsigned DEFAULT_WDOG  = 4;

endpackage

// File: rtl/spi_cmd_sequencer_sync_fifo.sv
// Single-clock show-ahead FIFO with full/empty/count; a write while full is
// accepted only when a read frees a slot in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     wr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     rd_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_wr, do_rd;

   always_comb begin
      do_rd    = rd_i && (count_q != '0);
      do_wr    = wr_i && ((count_q != FULL_CNT) || do_rd);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_wr) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Pulls command words from a FIFO, hands them to an SPI engine one at a time and
// queues the bytes received by data commands into a result FIFO.
module spi_cmd_sequencer
   import spi_cmd_sequencer_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_DEPTH,
   parameter int unsigned WDOG  = DEFAULT_WDOG
) (
   input  logic        clkin,
   input  logic        rst,
   input  logic        cmd_wr,
   input  logic [15:0] cmd_data,
   output logic        cmd_full,
   input  logic        res_rd,
   output logic [7:0]  res_data,
   output logic        res_empty,
   output logic        go,
   output logic [15:0] spi_data,
   input  logic        spi_state,
   input  logic [7:0]  spi_rdata,
   output logic        busy,
   output logic        err_ovf,
   output logic        err_wdog,
   input  logic        err_clr
);

   localparam int unsigned WW = $clog2(WDOG + 1);
   localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG - 1);

   state_e              state_q, state_d;
   logic [15:0]         spi_data_q, spi_data_d;
   logic [WW-1:0]       wdog_q, wdog_d;
   logic                err_ovf_q, err_ovf_d;
   logic                err_wdog_q, err_wdog_d;
   logic                cmd_pop, res_push, wdog_fire;
   logic                cmd_empty, res_full;
   logic [15:0]         cmd_head;
   logic [$clog2(DEPTH):0] cmd_count_unused, res_count_unused;

   sync_fifo #(
      .WIDTH (16),
      .DEPTH (DEPTH)
   ) u_cmd_fifo (
      .clk_i   (clkin),
      .rst_i   (rst),
      .wr_i    (cmd_wr),
      .wdata_i (cmd_data),
      .rd_i    (cmd_pop),
      .rdata_o (cmd_head),
      .full_o  (cmd_full),
      .empty_o (cmd_empty),
      .count_o (cmd_count_unused)
   );

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_res_fifo (
      .clk_i   (clkin),
      .rst_i   (rst),
      .wr_i    (res_push),
      .wdata_i (spi_rdata),
      .rd_i    (res_rd),
      .rdata_o (res_data),
      .full_o  (res_full),
      .empty_o (res_empty),
      .count_o (res_count_unused)
   );

   always_ff @(posedge clkin) begin
      if (rst) begin
         state_q    <= StIdle;
         spi_data_q <= '0;
         wdog_q     <= '0;
         err_ovf_q  <= 1'b0;
         err_wdog_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         spi_data_q <= spi_data_d;
         wdog_q     <= wdog_d;
         err_ovf_q  <= err_ovf_d;
         err_wdog_q <= err_wdog_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      spi_data_d = spi_data_q;
      wdog_d     = '0;
      cmd_pop    = 1'b0;
      res_push   = 1'b0;
      wdog_fire  = 1'b0;
      unique case (state_q)
         StIdle: begin
            // A data command needs a free result slot before it may start.
            if (!cmd_empty && (cmd_head[CMD_CS_BIT] || !res_full)) begin
               cmd_pop    = 1'b1;
               spi_data_d = cmd_head;
               state_d    = StIssue;
            end
         end
         StIssue: state_d = spi_data_q[CMD_CS_BIT] ? StIdle : StWaitStart;
         StWaitStart: begin
            if (spi_state) begin
               state_d = StWaitDone;
            end else if (wdog_q == WDOG_LAST) begin
               wdog_fire = 1'b1;
               state_d   = StIdle;
            end else begin
               wdog_d = wdog_q + WW'(1);
            end
         end
         StWaitDone: begin
            if (!spi_state) begin
               res_push = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // A set event in the same cycle as err_clr takes priority.
      err_ovf_d  = (cmd_wr && cmd_full && !cmd_pop) || (err_ovf_q && !err_clr);
      err_wdog_d = wdog_fire || (err_wdog_q && !err_clr);
   end

   always_comb begin
      go       = (state_q == StIssue);
      spi_data = spi_data_q;
      busy     = (state_q != StIdle) || !cmd_empty;
      err_ovf  = err_ovf_q;
      err_wdog = err_wdog_q;
   end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Self-checking bench for spi_cmd_sequencer with a behavioural SPI engine, a go
// scoreboard and a result scoreboard.
module tb_spi_cmd_sequencer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned WDOG  = 4;

   logic        clkin = 1'b0;
   logic        rst, cmd_wr, res_rd, err_clr, spi_state;
   logic [15:0] cmd_data;
   logic [7:0]  spi_rdata;
   logic        cmd_full, res_empty, go, busy, err_ovf, err_wdog;
   logic [7:0]  res_data;
   logic [15:0] spi_data;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Engine modes: 0 normal, 1 never starts, 2 stays busy forever.
   int          eng_mode = 0;
   int          eng_cnt  = 0;
   logic        prev_go  = 1'b0;
   logic [15:0] last_go  = '0;

   logic [15:0] exp_go[$];
   logic [7:0]  exp_res[$];
   int          go_times[$];

   typedef struct {
      logic [15:0] cmd;
      logic        has_res;
      logic [7:0]  res;
   } vec_t;
   vec_t vecs[6];

   always #5 clkin = ~clkin;
   always @(posedge clkin) cyc++;

   spi_cmd_sequencer #(
      .DEPTH (DEPTH),
      .WDOG  (WDOG)
   ) dut (
      .clkin     (clkin),
      .rst       (rst),
      .cmd_wr    (cmd_wr),
      .cmd_data  (cmd_data),
      .cmd_full  (cmd_full),
      .res_rd    (res_rd),
      .res_data  (res_data),
      .res_empty (res_empty),
      .go        (go),
      .spi_data  (spi_data),
      .spi_state (spi_state),
      .spi_rdata (spi_rdata),
      .busy      (busy),
      .err_ovf   (err_ovf),
      .err_wdog  (err_wdog),
      .err_clr   (err_clr)
   );

   function automatic logic [7:0] eng_resp(input logic [15:0] w);
      return w[7:0] ^ 8'hA2;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Go monitor plus SPI engine model, both on the falling edge.
   always @(negedge clkin) begin
      if (rst) begin
         spi_state = 1'b0;
         eng_cnt   = 0;
         prev_go   = 1'b0;
         last_go   = '0;
      end else begin
         if (go) begin
            chk("go_single_pulse", {31'd0, prev_go}, 32'd0);
            if (exp_go.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL go_unexpected: actual spi_data 0x%0h required no go", spi_data);
            end else begin
               chk("go_word", {16'd0, spi_data}, {16'd0, exp_go.pop_front()});
            end
            last_go = spi_data;
            go_times.push_back(cyc);
         end
         if (eng_mode == 0 && eng_cnt != 0)
            chk("spi_data_hold", {16'd0, spi_data}, {16'd0, last_go});
         case (eng_mode)
            0: begin
               if (eng_cnt != 0) begin
                  eng_cnt--;
                  if (eng_cnt == 0) spi_state = 1'b0;
               end else if (go && !spi_data[15]) begin
                  spi_rdata = eng_resp(spi_data);
                  spi_state = 1'b1;
                  eng_cnt   = 4;
               end else begin
                  spi_state = 1'b0;
               end
            end
            1: spi_state = 1'b0;
            default: begin
               spi_state = 1'b1;
               if (go && !spi_data[15]) spi_rdata = eng_resp(spi_data);
            end
         endcase
         prev_go = go;
      end
   end

   task automatic write_cmd(input logic [15:0] w);
      cmd_data = w;
      cmd_wr   = 1'b1;
      @(negedge clkin);
      cmd_wr   = 1'b0;
   endtask

   task automatic pop_chk(input string name);
      chk({name, "_avail"}, {31'd0, res_empty}, 32'd0);
      if (exp_res.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: actual 0x%0h required no result", name, res_data);
      end else begin
         chk(name, {24'd0, res_data}, {24'd0, exp_res.pop_front()});
      end
      res_rd = 1'b1;
      @(negedge clkin);
      res_rd = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int i;
      for (i = 0; i < 100; i++) begin
         if (!busy && !spi_state) break;
         @(negedge clkin);
      end
      chk({name, "_idle"}, {31'd0, (i < 100)}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: actual still running required finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic seen;
      vecs[0] = '{16'h0807, 1'b1, 8'hA5};
      vecs[1] = '{16'h8000, 1'b0, 8'h00};
      vecs[2] = '{16'h0855, 1'b1, 8'hF7};
      vecs[3] = '{16'h8001, 1'b0, 8'h00};
      vecs[4] = '{16'h08FF, 1'b1, 8'h5D};
      vecs[5] = '{16'h043C, 1'b1, 8'h9E};

      rst = 1'b1; cmd_wr = 1'b0; cmd_data = '0; res_rd = 1'b0; err_clr = 1'b0;
      spi_state = 1'b0; spi_rdata = '0;
      repeat (3) @(negedge clkin);
      chk("rst_go", {31'd0, go}, 32'd0);
      chk("rst_res_empty", {31'd0, res_empty}, 32'd1);
      chk("rst_cmd_full", {31'd0, cmd_full}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_errs", {30'd0, err_ovf, err_wdog}, 32'd0);
      chk("rst_spi_data", {16'd0, spi_data}, 32'd0);
      rst = 1'b0;
      @(negedge clkin);

      // Latency: go one cycle late, single pulse, result A5.
      exp_go.push_back(16'h0807);
      exp_res.push_back(8'hA5);
      write_cmd(16'h0807);
      chk("lat_go_cycle1", {31'd0, go}, 32'd0);
      @(negedge clkin);
      chk("lat_go_cycle2", {31'd0, go}, 32'd1);
      @(negedge clkin);
      chk("lat_go_cycle3", {31'd0, go}, 32'd0);
      wait_idle("lat");
      pop_chk("lat_res");
      chk("lat_res_drained", {31'd0, res_empty}, 32'd1);

      for (int v = 0; v < 6; v++) begin
         exp_go.push_back(vecs[v].cmd);
         if (vecs[v].has_res) exp_res.push_back(vecs[v].res);
         write_cmd(vecs[v].cmd);
         wait_idle("vec");
         if (vecs[v].has_res) pop_chk("vec_res");
         chk("vec_res_empty", {31'd0, res_empty}, 32'd1);
      end

      // Burst of CS, data, CS: CS words return to IDLE without waiting.
      go_times.delete();
      exp_go.push_back(16'h8000);
      exp_go.push_back(16'h0855);
      exp_go.push_back(16'h8001);
      exp_res.push_back(8'hF7);
      write_cmd(16'h8000);
      write_cmd(16'h0855);
      write_cmd(16'h8001);
      wait_idle("burst");
      chk("burst_go_count", go_times.size(), 3);
      if (go_times.size() >= 2) chk("burst_cs_gap", go_times[1] - go_times[0], 2);
      pop_chk("burst_res");
      chk("burst_one_result", {31'd0, res_empty}, 32'd1);

      // Command FIFO overflow with the engine stuck busy.
      eng_mode = 2;
      @(negedge clkin);
      exp_go.push_back(16'h0811);
      exp_res.push_back(8'hB3);
      write_cmd(16'h0811);
      for (int k = 0; k < 3; k++) begin
         exp_go.push_back(16'h8000 | 16'(k & 1));
         write_cmd(16'h8000 | 16'(k & 1));
      end
      chk("ovf_not_full_3", {31'd0, cmd_full}, 32'd0);
      exp_go.push_back(16'h8001);
      write_cmd(16'h8001);
      chk("ovf_full_4", {31'd0, cmd_full}, 32'd1);
      chk("ovf_no_err_yet", {31'd0, err_ovf}, 32'd0);
      write_cmd(16'h0899);
      chk("ovf_err", {31'd0, err_ovf}, 32'd1);
      chk("ovf_still_full", {31'd0, cmd_full}, 32'd1);
      eng_mode = 0;
      wait_idle("ovf");
      pop_chk("ovf_res");
      chk("ovf_dropped_never_issued", exp_go.size(), 0);
      chk("ovf_sticky", {31'd0, err_ovf}, 32'd1);
      err_clr = 1'b1;
      @(negedge clkin);
      err_clr = 1'b0;
      chk("ovf_cleared", {31'd0, err_ovf}, 32'd0);

      // Result FIFO full blocks the next data command until a pop.
      for (int k = 0; k < 4; k++) begin
         exp_go.push_back(16'h0800 | 16'(k));
         exp_res.push_back(eng_resp(16'(k)));
         write_cmd(16'h0800 | 16'(k));
      end
      wait_idle("rfull");
      exp_go.push_back(16'h0810);
      exp_res.push_back(8'hB2);
      write_cmd(16'h0810);
      seen = 1'b0;
      repeat (8) begin
         @(negedge clkin);
         seen |= go;
      end
      chk("rfull_no_go", {31'd0, seen}, 32'd0);
      chk("rfull_busy", {31'd0, busy}, 32'd1);
      pop_chk("rfull_res");
      seen = 1'b0;
      repeat (2) begin
         @(negedge clkin);
         seen |= go;
      end
      chk("rfull_go_after_pop", {31'd0, seen}, 32'd1);
      wait_idle("rfull2");
      for (int k = 0; k < 4; k++) pop_chk("rfull_drain");
      chk("rfull_empty", {31'd0, res_empty}, 32'd1);

      // Watchdog: engine never starts.
      eng_mode = 1;
      exp_go.push_back(16'h0812);
      write_cmd(16'h0812);
      repeat (5) @(negedge clkin);
      chk("wdog_not_yet", {31'd0, err_wdog}, 32'd0);
      @(negedge clkin);
      chk("wdog_fired", {31'd0, err_wdog}, 32'd1);
      chk("wdog_idle", {31'd0, busy}, 32'd0);
      chk("wdog_no_result", {31'd0, res_empty}, 32'd1);
      err_clr = 1'b1;
      @(negedge clkin);
      err_clr = 1'b0;
      chk("wdog_cleared", {31'd0, err_wdog}, 32'd0);
      eng_mode = 0;
      @(negedge clkin);

      // Reset while waiting for the engine to finish.
      eng_mode = 2;
      @(negedge clkin);
      exp_go.push_back(16'h0822);
      write_cmd(16'h0822);
      write_cmd(16'h8000);
      repeat (4) @(negedge clkin);
      rst = 1'b1;
      @(negedge clkin);
      eng_mode = 0;
      exp_go.delete();
      exp_res.delete();
      rst = 1'b0;
      chk("mrst_go", {31'd0, go}, 32'd0);
      chk("mrst_res_empty", {31'd0, res_empty}, 32'd1);
      chk("mrst_cmd_full", {31'd0, cmd_full}, 32'd0);
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      @(negedge clkin);
      exp_go.push_back(16'h0807);
      exp_res.push_back(8'hA5);
      write_cmd(16'h0807);
      wait_idle("recover");
      pop_chk("recover_res");
      chk("final_go_queue", exp_go.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
